// File: rtl/rs_pkg.sv
// Shared GF(2^8) arithmetic, symbol type and controller state for the RS(18,16) syndrome path.
package rs_pkg;
  localparam int SYM_W = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam logic [SYM_W-1:0] GF_ALPHA = 8'h02;

  typedef logic [SYM_W-1:0] sym_t;
  typedef enum logic {ACC, OUT} state_t;

  // Shift-and-add product reduced by GF_POLY; constant operands fold to XOR trees.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ x;
      x = x[SYM_W-1] ? ({x[SYM_W-2:0], 1'b0} ^ GF_POLY[SYM_W-1:0]) : {x[SYM_W-2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic sym_t gf_add(input sym_t a, input sym_t b);
    return a ^ b;
  endfunction

  function automatic sym_t gf_alpha_pow(input int j);
    sym_t p;
    p = 8'h01;
    for (int i = 0; i < j; i++) p = gf_mul(p, GF_ALPHA);
    return p;
  endfunction
endpackage

// File: rtl/rs_syn_cell.sv
// One syndrome accumulator: acc <= acc*alpha^J + sym on enable, cleared on clr.
module rs_syn_cell
  import rs_pkg::*;
#(
  parameter int J = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  sym_t sym,
  output sym_t acc
);
  localparam sym_t COEF = gf_alpha_pow(J);

  sym_t prod;
  sym_t nxt;

  assign prod = gf_mul(acc, COEF);
  assign nxt  = gf_add(prod, sym);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) acc <= '0;
    else if (en)       acc <= nxt;
  end
endmodule

// File: rtl/rs_syndrome_seq.sv
// Streaming RS(18,16) syndrome controller: one symbol per accept, Horner accumulation, valid/ready out.
// Optional RS_SYN_ZERO_FLAG_EN adds out_clean (error-free codeword flag).
module rs_syndrome_seq
  import rs_pkg::*;
#(
  parameter int N            = 18,
  parameter int SYMBOL_WIDTH = SYM_W,
  parameter int NSYN         = 2,
  parameter int CNT_W        = $clog2(N)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SYMBOL_WIDTH-1:0]      in_sym,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NSYN*SYMBOL_WIDTH-1:0] out_syn,
  output logic                         out_frame_err
`ifdef RS_SYN_ZERO_FLAG_EN
  ,
  output logic                         out_clean
`endif
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t                           state;
  logic [CNT_W-1:0]                 cnt;
  logic                             err;
  logic                             accept;
  logic                             drain;
  logic [NSYN-1:0][SYMBOL_WIDTH-1:0] syn;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  for (genvar g = 0; g < NSYN; g++) begin : g_cell
    rs_syn_cell #(.J(g + 1)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (drain),
      .en    (accept),
      .sym   (in_sym),
      .acc   (syn[g])
    );
  end

  assign out_syn       = syn;
  assign out_frame_err = err;

`ifdef RS_SYN_ZERO_FLAG_EN
  // Derived from the registers frozen at the OUT transition, so it holds with out_valid.
  assign out_clean = out_valid & ~(|syn) & ~err;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACC;
      cnt       <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (cnt == LAST_CNT) begin
              cnt       <= '0;
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              if (!in_last) err <= 1'b1;
            end else begin
              // An early in_last only flags the frame; the codeword still runs to N symbols.
              cnt <= cnt + 1'b1;
              if (in_last) err <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= ACC;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule
